ysyx_22050550_axi_sram_v2: RTL and testbench
============================================

Name: ysyx_22050550_axi_sram_v2

Overview:
Parametrised AXI4-style memory slave, successor of the single-mode DPI SRAM model. It provides independent read and write channel FSMs and supports FIXED, INCR and WRAP bursts. Read latency per beat is configurable, and SLVERR is reported on illegal or out-of-range accesses. Storage is an internal word array by default; DPI backing is optional. It sits behind the cache and MMIO arbiter as the NPC main-memory model.

Parameters:
DATA_W, 64, data bus width in bits; power of two, 32..128
ADDR_W, 64, address width
DEPTH, 4096, number of DATA_W-bit words
BASE_ADDR, 64'h8000_0000, byte address of word 0
READ_LAT, 0, wait cycles before each read beat; 0..15

Ports:
clock  in  1  clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
io_Sram_ar_valid  in  1  read address valid
io_Sram_ar_ready  out  1  read address ready
io_Sram_ar_bits_addr  in  ADDR_W  read start byte address
io_ar_len  in  8  beats minus 1
io_ar_size  in  3  log2 bytes per beat
io_ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
io_Sram_r_valid  out  1  read data valid
io_Sram_r_ready  in  1  read data ready
io_Sram_r_bits_data  out  DATA_W  read word, full aligned word
io_Sram_r_rresp  out  2  00 OKAY, 10 SLVERR
io_Sram_r_bits_last  out  1  final read beat
io_Sram_aw_valid, io_Sram_aw_ready, io_Sram_aw_bits_addr, io_aw_len, io_aw_size, io_aw_burst  write-address group; same widths and meanings as AR
io_Sram_w_valid  in  1  write data valid
io_Sram_w_ready  out  1  write data ready
io_Sram_w_bits_data  in  DATA_W  write data
io_Sram_w_bits_strb  in  DATA_W/8  byte strobes
io_Sram_w_bits_last  in  1  master's last-beat flag
io_b_valid  out  1  write response valid
io_b_ready  in  1  write response ready
io_b_bresp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: ar_ready=1, aw_ready=1, r_valid=0, r_last=0, r_data=0, rresp=00, w_ready=0, b_valid=0, bresp=00.
  - Both FSMs go to idle; any in-flight burst is aborted.
  - Memory contents are not cleared; beats already written are retained.
- Read FSM, states R_IDLE, R_WAIT, R_DATA:
  - R_IDLE: ar_ready=1. On ar handshake, capture addr, len, size and burst, load beat counter=len and latency counter=READ_LAT. Go to R_WAIT if READ_LAT>0, else R_DATA.
  - R_WAIT: decrement latency counter; enter R_DATA when it reaches 1.
  - R_DATA: r_valid=1; data and resp stay stable while r_ready=0. r_last=1 when counter==0.
  - On r handshake with last: go to R_IDLE; ar_ready rises the next cycle.
  - On r handshake otherwise: advance the address, decrement the counter, reload latency, then go to R_WAIT (or stay in R_DATA if READ_LAT=0).
  - r_data=0 whenever r_valid=0.
- Address advance, step = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr+step.
  - WRAP: boundary B=(len+1)*step; next=(addr & ~(B-1)) | ((addr+step) & (B-1)).
- Word index = (addr-BASE_ADDR) >> log2(DATA_W/8).
- Error rules:
  - Burst-level SLVERR on every beat of the burst: size > log2(DATA_W/8); burst=11; WRAP with len not in {1,3,7,15}; WRAP with addr not size-aligned.
  - Beat-level SLVERR: index >= DEPTH or addr < BASE_ADDR.
  - An errored read beat returns data 0. An errored write beat is suppressed.
  - Erroring bursts still transfer the full len+1 beats.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready=1. On aw handshake, capture fields and load counter=len; go to W_DATA.
  - W_DATA: w_ready=1. Each w handshake writes the bytes with strb=1 that lie inside the lanes addressed by size and addr; other strobes are masked. Then advance the address and decrement the counter.
  - On the handshake with counter==0, go to W_RESP.
  - W_RESP: b_valid=1 until b_ready; then go to W_IDLE.
  - bresp=10 if any beat erred, or if w_last mismatched the slave count (set early, or clear on the final beat). Otherwise bresp=00.
- Concurrency: channels are fully independent. A read in the same cycle as a write to the same word returns the pre-write value; the write is visible from the next cycle.
- Write-data beats before the aw handshake are not accepted (w_ready=0).

Optional Feature:
YSYX_22050550_SRAM_DPI_EN
- Defined:
  - The internal array is removed.
  - Reads call pmem_read(word-aligned addr) combinationally in R_DATA.
  - Writes call pmem_write(addr, data, strb) at the w handshake edge.
  - DATA_W must equal 64; the DEPTH/BASE_ADDR range check is disabled.
- Undefined: internal DEPTH x DATA_W array; no DPI imports.

Test Plan:
- INCR read, len=3, size=3, addr 0x8000_0000, READ_LAT=0, words preloaded 0x11..0x44 -> four consecutive beats 0x11,0x22,0x33,0x44; r_last only on the fourth; ar_ready back high the next cycle.
- WRAP read, len=3, size=3, addr 0x8000_0010 -> beat addresses 0x10,0x18,0x00,0x08; READ_LAT=2 -> exactly 2 idle cycles before each beat; r_ready held low for 3 cycles mid-burst -> data held stable.
- Narrow write, size=0, addr 0x8000_0003, data 0xFFFF_FFFF_FFFF_FFFF, strb 0xFF -> only byte 3 changes; readback 0x0000_0000_FF00_0000 from a zeroed word; bresp=00.
- Out-of-range write at BASE_ADDR+DEPTH*8, len=1 -> both beats accepted, memory unchanged, bresp=10; read of the same address -> rresp=10, data 0.
- w_last asserted on beat 0 of a len=1 burst -> both beats written, bresp=10; b_valid held until b_ready rises after 5 cycles.
- reset pulled low mid read burst (after beat 1 of 4) -> r_valid=0 immediately, ar_ready=1; a new burst after release completes normally.

Source files
------------

// File: rtl/ysyx_22050550_axi_sram_v2_if.sv
// AXI4-style bus bundle between the NPC memory masters and the SRAM model.
// The master modport drives requests and write data; the slave modport
// drives the ready, read-data and response signals.
interface ysyx_22050550_axi_sram_v2_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  // Read address channel
  logic                  io_Sram_ar_valid;
  logic                  io_Sram_ar_ready;
  logic [ADDR_W-1:0]     io_Sram_ar_bits_addr;
  logic [7:0]            io_ar_len;
  logic [2:0]            io_ar_size;
  logic [1:0]            io_ar_burst;
  // Read data channel
  logic                  io_Sram_r_valid;
  logic                  io_Sram_r_ready;
  logic [DATA_W-1:0]     io_Sram_r_bits_data;
  logic [1:0]            io_Sram_r_rresp;
  logic                  io_Sram_r_bits_last;
  // Write address channel
  logic                  io_Sram_aw_valid;
  logic                  io_Sram_aw_ready;
  logic [ADDR_W-1:0]     io_Sram_aw_bits_addr;
  logic [7:0]            io_aw_len;
  logic [2:0]            io_aw_size;
  logic [1:0]            io_aw_burst;
  // Write data channel
  logic                  io_Sram_w_valid;
  logic                  io_Sram_w_ready;
  logic [DATA_W-1:0]     io_Sram_w_bits_data;
  logic [DATA_W/8-1:0]   io_Sram_w_bits_strb;
  logic                  io_Sram_w_bits_last;
  // Write response channel
  logic                  io_b_valid;
  logic                  io_b_ready;
  logic [1:0]            io_b_bresp;

  modport master (
    output io_Sram_ar_valid, io_Sram_ar_bits_addr, io_ar_len, io_ar_size, io_ar_burst,
    input  io_Sram_ar_ready,
    output io_Sram_r_ready,
    input  io_Sram_r_valid, io_Sram_r_bits_data, io_Sram_r_rresp, io_Sram_r_bits_last,
    output io_Sram_aw_valid, io_Sram_aw_bits_addr, io_aw_len, io_aw_size, io_aw_burst,
    input  io_Sram_aw_ready,
    output io_Sram_w_valid, io_Sram_w_bits_data, io_Sram_w_bits_strb, io_Sram_w_bits_last,
    input  io_Sram_w_ready,
    output io_b_ready,
    input  io_b_valid, io_b_bresp
  );

  modport slave (
    input  io_Sram_ar_valid, io_Sram_ar_bits_addr, io_ar_len, io_ar_size, io_ar_burst,
    output io_Sram_ar_ready,
    input  io_Sram_r_ready,
    output io_Sram_r_valid, io_Sram_r_bits_data, io_Sram_r_rresp, io_Sram_r_bits_last,
    input  io_Sram_aw_valid, io_Sram_aw_bits_addr, io_aw_len, io_aw_size, io_aw_burst,
    output io_Sram_aw_ready,
    input  io_Sram_w_valid, io_Sram_w_bits_data, io_Sram_w_bits_strb, io_Sram_w_bits_last,
    output io_Sram_w_ready,
    input  io_b_ready,
    output io_b_valid, io_b_bresp
  );
endinterface

// File: rtl/ysyx_22050550_axi_sram_v2.sv
// NPC main-memory model: AXI4-style slave with independent read and write
// FSMs, FIXED/INCR/WRAP bursts, per-beat read latency and SLVERR reporting.
// Storage is an internal DEPTH x DATA_W word array.
module ysyx_22050550_axi_sram_v2 #(
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 64,
  parameter int          DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          READ_LAT  = 0
) (
  input logic clock,
  input logic reset,
  ysyx_22050550_axi_sram_v2_if.slave bus
);

  localparam int                BYTES     = DATA_W / 8;
  localparam int                LOG_BYTES = $clog2(BYTES);
  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        LAT       = 4'(READ_LAT);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  function automatic logic [ADDR_W-1:0] step_of(input logic [2:0] size);
    return ADDR_W'(1) << size;
  endfunction

  // Address of the beat following addr within the burst.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0]        len,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] bound;
    step  = step_of(size);
    bound = (ADDR_W'(len) + ADDR_W'(1)) * step;
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (addr & ~(bound - ADDR_W'(1))) | ((addr + step) & (bound - ADDR_W'(1)));
      default:     return addr + step;
    endcase
  endfunction

  // Whole-burst protocol violations; flagged on every beat of the burst.
  function automatic logic burst_err(input logic [ADDR_W-1:0] addr,
                                     input logic [7:0]        len,
                                     input logic [2:0]        size,
                                     input logic [1:0]        burst);
    logic err;
    err = 1'b0;
    if (size > 3'(LOG_BYTES)) err = 1'b1;
    if (burst == BURST_RSVD) err = 1'b1;
    if (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) err = 1'b1;
    if (burst == BURST_WRAP && (addr & (step_of(size) - ADDR_W'(1))) != '0) err = 1'b1;
    return err;
  endfunction

  // Per-beat range check against the backing array.
  function automatic logic beat_err(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return (addr < BASE) || ((off >> LOG_BYTES) >= ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return IDX_W'(off >> LOG_BYTES);
  endfunction

  // Byte lanes covered by a beat of 2**size bytes at addr.
  function automatic logic [BYTES-1:0] lane_mask(input logic [ADDR_W-1:0] addr,
                                                 input logic [2:0]        size);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++)
      m[i] = (LOG_BYTES'(i) >> size) == (addr[LOG_BYTES-1:0] >> size);
    return m;
  endfunction

  // ------------------------------------------------------------------
  // Read channel
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  r_state_e          r_state, r_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_berr;
  logic [3:0]        r_lat;
  logic              ar_hs, r_hs, r_err;
  logic [DATA_W-1:0] rd_word;

  assign ar_hs = bus.io_Sram_ar_valid && bus.io_Sram_ar_ready;
  assign r_hs  = bus.io_Sram_r_valid && bus.io_Sram_r_ready;
  assign r_err = r_berr || beat_err(r_addr);

  // Read state register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read next-state logic.
  // NOTE: every always_comb output is defaulted first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = (LAT != 4'd0) ? R_WAIT : R_DATA;
      R_WAIT: if (r_lat == 4'd1) r_next = R_DATA;
      R_DATA: if (r_hs) begin
        if (r_cnt == 8'd0)      r_next = R_IDLE;
        else if (LAT != 4'd0)   r_next = R_WAIT;
        else                    r_next = R_DATA;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read burst bookkeeping: capture, latency countdown, address advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_berr  <= 1'b0;
      r_lat   <= '0;
    end else if (r_state == R_IDLE && ar_hs) begin
      r_addr  <= bus.io_Sram_ar_bits_addr;
      r_len   <= bus.io_ar_len;
      r_cnt   <= bus.io_ar_len;
      r_size  <= bus.io_ar_size;
      r_burst <= bus.io_ar_burst;
      r_berr  <= burst_err(bus.io_Sram_ar_bits_addr, bus.io_ar_len, bus.io_ar_size, bus.io_ar_burst);
      r_lat   <= LAT;
    end else if (r_state == R_WAIT) begin
      r_lat <= r_lat - 4'd1;
    end else if (r_state == R_DATA && r_hs && r_cnt != 8'd0) begin
      r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
      r_cnt  <= r_cnt - 8'd1;
      r_lat  <= LAT;
    end
  end

  // Read channel outputs; data is forced to zero outside valid or on error.
  always_comb begin
    bus.io_Sram_ar_ready    = (r_state == R_IDLE);
    bus.io_Sram_r_valid     = (r_state == R_DATA);
    bus.io_Sram_r_bits_last = (r_state == R_DATA) && (r_cnt == 8'd0);
    bus.io_Sram_r_rresp     = (r_state == R_DATA && r_err) ? 2'b10 : 2'b00;
    bus.io_Sram_r_bits_data = (r_state == R_DATA && !r_err) ? rd_word : '0;
  end

  // ------------------------------------------------------------------
  // Write channel
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  w_state_e          w_state, w_next;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_berr;
  logic              w_flag;
  logic              aw_hs, w_hs, w_beat_err, w_we;
  logic [BYTES-1:0]  w_be;

  assign aw_hs      = bus.io_Sram_aw_valid && bus.io_Sram_aw_ready;
  assign w_hs       = bus.io_Sram_w_valid && bus.io_Sram_w_ready;
  assign w_beat_err = w_berr || beat_err(w_addr);
  assign w_we       = w_hs && !w_beat_err;
  assign w_be       = bus.io_Sram_w_bits_strb & lane_mask(w_addr, w_size);

  // Write state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write next-state logic.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_cnt == 8'd0) w_next = W_RESP;
      W_RESP:  if (bus.io_b_ready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst bookkeeping and sticky error for the response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_berr  <= 1'b0;
      w_flag  <= 1'b0;
    end else if (aw_hs) begin
      w_addr  <= bus.io_Sram_aw_bits_addr;
      w_len   <= bus.io_aw_len;
      w_cnt   <= bus.io_aw_len;
      w_size  <= bus.io_aw_size;
      w_burst <= bus.io_aw_burst;
      w_berr  <= burst_err(bus.io_Sram_aw_bits_addr, bus.io_aw_len, bus.io_aw_size, bus.io_aw_burst);
      w_flag  <= 1'b0;
    end else if (w_hs) begin
      // A w_last that disagrees with the slave's own beat count is an error.
      w_flag <= w_flag || w_beat_err || (bus.io_Sram_w_bits_last != (w_cnt == 8'd0));
      if (w_cnt != 8'd0) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt - 8'd1;
      end
    end
  end

  // Write channel outputs.
  always_comb begin
    bus.io_Sram_aw_ready = (w_state == W_IDLE);
    bus.io_Sram_w_ready  = (w_state == W_DATA);
    bus.io_b_valid       = (w_state == W_RESP);
    bus.io_b_bresp       = (w_state == W_RESP && w_flag) ? 2'b10 : 2'b00;
  end

  // ------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  // Asynchronous read: a same-cycle write to this word lands after the edge,
  // so the reader sees the pre-write value.
  assign rd_word = mem[word_idx(r_addr)];

  // Byte-masked store of the accepted write beat.
  // NOTE: the array has no reset; contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (w_we)
      for (int i = 0; i < BYTES; i++)
        if (w_be[i]) mem[word_idx(w_addr)][8*i +: 8] <= bus.io_Sram_w_bits_data[8*i +: 8];
  end

endmodule

// File: tb/tb_ysyx_22050550_axi_sram_v2.sv
// Directed, table-driven bench for the AXI SRAM model. Two instances share
// one stimulus driver: u_dut0 with zero read latency, u_dut2 with READ_LAT=2;
// `sel` routes valid/ready handshakes to one of them.
module tb_ysyx_22050550_axi_sram_v2;

  localparam int LIMIT = 100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_22050550_axi_sram_v2_if bus0 ();
  ysyx_22050550_axi_sram_v2_if bus1 ();

  ysyx_22050550_axi_sram_v2 #(.READ_LAT(0)) u_dut0 (.clock(clk), .reset(rst_n), .bus(bus0));
  ysyx_22050550_axi_sram_v2 #(.READ_LAT(2)) u_dut2 (.clock(clk), .reset(rst_n), .bus(bus1));

  // Shared stimulus.
  logic        sel;
  logic        ar_valid, r_ready, aw_valid, w_valid, w_last, b_ready;
  logic [63:0] ar_addr, aw_addr, w_data;
  logic [7:0]  ar_len, aw_len, w_strb;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, aw_burst;

  assign bus0.io_Sram_ar_valid = ar_valid && !sel;
  assign bus1.io_Sram_ar_valid = ar_valid && sel;
  assign bus0.io_Sram_r_ready  = r_ready && !sel;
  assign bus1.io_Sram_r_ready  = r_ready && sel;
  assign bus0.io_Sram_aw_valid = aw_valid && !sel;
  assign bus1.io_Sram_aw_valid = aw_valid && sel;
  assign bus0.io_Sram_w_valid  = w_valid && !sel;
  assign bus1.io_Sram_w_valid  = w_valid && sel;
  assign bus0.io_b_ready       = b_ready && !sel;
  assign bus1.io_b_ready       = b_ready && sel;

  assign bus0.io_Sram_ar_bits_addr = ar_addr;  assign bus1.io_Sram_ar_bits_addr = ar_addr;
  assign bus0.io_ar_len            = ar_len;   assign bus1.io_ar_len            = ar_len;
  assign bus0.io_ar_size           = ar_size;  assign bus1.io_ar_size           = ar_size;
  assign bus0.io_ar_burst          = ar_burst; assign bus1.io_ar_burst          = ar_burst;
  assign bus0.io_Sram_aw_bits_addr = aw_addr;  assign bus1.io_Sram_aw_bits_addr = aw_addr;
  assign bus0.io_aw_len            = aw_len;   assign bus1.io_aw_len            = aw_len;
  assign bus0.io_aw_size           = aw_size;  assign bus1.io_aw_size           = aw_size;
  assign bus0.io_aw_burst          = aw_burst; assign bus1.io_aw_burst          = aw_burst;
  assign bus0.io_Sram_w_bits_data  = w_data;   assign bus1.io_Sram_w_bits_data  = w_data;
  assign bus0.io_Sram_w_bits_strb  = w_strb;   assign bus1.io_Sram_w_bits_strb  = w_strb;
  assign bus0.io_Sram_w_bits_last  = w_last;   assign bus1.io_Sram_w_bits_last  = w_last;

  // Selected-instance outputs.
  logic        m_ar_ready, m_r_valid, m_r_last, m_aw_ready, m_w_ready, m_b_valid;
  logic [63:0] m_r_data;
  logic [1:0]  m_rresp, m_bresp;

  assign m_ar_ready = sel ? bus1.io_Sram_ar_ready    : bus0.io_Sram_ar_ready;
  assign m_r_valid  = sel ? bus1.io_Sram_r_valid     : bus0.io_Sram_r_valid;
  assign m_r_last   = sel ? bus1.io_Sram_r_bits_last : bus0.io_Sram_r_bits_last;
  assign m_r_data   = sel ? bus1.io_Sram_r_bits_data : bus0.io_Sram_r_bits_data;
  assign m_rresp    = sel ? bus1.io_Sram_r_rresp     : bus0.io_Sram_r_rresp;
  assign m_aw_ready = sel ? bus1.io_Sram_aw_ready    : bus0.io_Sram_aw_ready;
  assign m_w_ready  = sel ? bus1.io_Sram_w_ready     : bus0.io_Sram_w_ready;
  assign m_b_valid  = sel ? bus1.io_b_valid          : bus0.io_b_valid;
  assign m_bresp    = sel ? bus1.io_b_bresp          : bus0.io_b_bresp;

  typedef struct {
    bit          is_wr;
    bit          sel;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] d0;          // beat b carries d0 * (b + 1)
    logic [7:0]  strb;
    int          early_last;  // write beat carrying a premature w_last, -1 none
    int          b_delay;     // cycles b_ready stays low after b_valid
    int          stall_beat;  // read beat held with r_ready low for 3 cycles, -1 none
    int          exp_gap;     // idle cycles before each read beat
    logic [1:0]  exp_resp;
    logic [63:0] exp [4];
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit wr, bit s, logic [63:0] a, logic [7:0] l, logic [2:0] z,
                              logic [1:0] bu, logic [63:0] d, logic [7:0] st, int el, int bd,
                              int sb, int gap, logic [1:0] rs,
                              logic [63:0] e0, logic [63:0] e1, logic [63:0] e2, logic [63:0] e3);
    vec_t v;
    v.is_wr = wr; v.sel = s; v.addr = a; v.len = l; v.size = z; v.burst = bu;
    v.d0 = d; v.strb = st; v.early_last = el; v.b_delay = bd; v.stall_beat = sb;
    v.exp_gap = gap; v.exp_resp = rs;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic do_write(input int id, input vec_t v);
    int n;
    check($sformatf("v%0d.w_ready_before_aw", id), 64'(m_w_ready), 64'd0);
    aw_addr = v.addr; aw_len = v.len; aw_size = v.size; aw_burst = v.burst; aw_valid = 1'b1;
    n = 0;
    while (!m_aw_ready && n < LIMIT) begin tick(); n++; end
    check($sformatf("v%0d.aw_timeout", id), 64'(n >= LIMIT), 64'd0);
    tick();
    aw_valid = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      w_valid = 1'b1;
      w_data  = v.d0 * 64'(b + 1);
      w_strb  = v.strb;
      w_last  = (b == int'(v.len)) || (b == v.early_last);
      n = 0;
      while (!m_w_ready && n < LIMIT) begin tick(); n++; end
      check($sformatf("v%0d.b%0d.w_timeout", id, b), 64'(n >= LIMIT), 64'd0);
      tick();
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    n = 0;
    while (!m_b_valid && n < LIMIT) begin tick(); n++; end
    check($sformatf("v%0d.b_timeout", id), 64'(n >= LIMIT), 64'd0);
    for (int k = 0; k < v.b_delay; k++) begin
      tick();
      check($sformatf("v%0d.b_valid_held%0d", id, k), 64'(m_b_valid), 64'd1);
    end
    check($sformatf("v%0d.bresp", id), 64'(m_bresp), 64'(v.exp_resp));
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check($sformatf("v%0d.b_valid_drop", id), 64'(m_b_valid), 64'd0);
  endtask

  task automatic do_read(input int id, input vec_t v);
    int n;
    ar_addr = v.addr; ar_len = v.len; ar_size = v.size; ar_burst = v.burst; ar_valid = 1'b1;
    r_ready = 1'b1;
    n = 0;
    while (!m_ar_ready && n < LIMIT) begin tick(); n++; end
    check($sformatf("v%0d.ar_timeout", id), 64'(n >= LIMIT), 64'd0);
    tick();
    ar_valid = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      n = 0;
      while (!m_r_valid && n < LIMIT) begin tick(); n++; end
      check($sformatf("v%0d.b%0d.gap", id, b), 64'(n), 64'(v.exp_gap));
      if (b == v.stall_beat) begin
        r_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          check($sformatf("v%0d.b%0d.stall_valid%0d", id, b, k), 64'(m_r_valid), 64'd1);
          check($sformatf("v%0d.b%0d.stall_data%0d", id, b, k), m_r_data, v.exp[b]);
        end
        r_ready = 1'b1;
      end
      check($sformatf("v%0d.b%0d.data", id, b), m_r_data, v.exp[b]);
      check($sformatf("v%0d.b%0d.rresp", id, b), 64'(m_rresp), 64'(v.exp_resp));
      check($sformatf("v%0d.b%0d.last", id, b), 64'(m_r_last), 64'(b == int'(v.len)));
      tick();
    end
    r_ready = 1'b0;
    check($sformatf("v%0d.ar_ready_after", id), 64'(m_ar_ready), 64'd1);
    check($sformatf("v%0d.r_valid_after", id), 64'(m_r_valid), 64'd0);
    check($sformatf("v%0d.r_data_idle", id), m_r_data, 64'd0);
  endtask

  initial begin
    vec_t vecs[18];
    vec_t tail;

    //             wr s  addr                len  sz    burst  d0                      strb   el bd  sb gap rsp    expected beats
    vecs[0]  = mk(1, 0, 64'h8000_0000, 8'd3, 3'd3, 2'b01, 64'h11,                 8'hFF, -1, 0, -1, 0, 2'b00, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 64'h8000_0000, 8'd3, 3'd3, 2'b01, 0,                      8'h00, -1, 0, -1, 0, 2'b00, 64'h11, 64'h22, 64'h33, 64'h44);
    vecs[2]  = mk(1, 1, 64'h8000_0000, 8'd3, 3'd3, 2'b01, 64'hA0,                 8'hFF, -1, 0, -1, 0, 2'b00, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 64'h8000_0010, 8'd3, 3'd3, 2'b10, 0,                      8'h00, -1, 0,  1, 2, 2'b00, 64'h1E0, 64'h280, 64'hA0, 64'h140);
    vecs[4]  = mk(1, 0, 64'h8000_0000, 8'd0, 3'd3, 2'b01, 64'h0,                  8'hFF, -1, 0, -1, 0, 2'b00, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 64'h8000_0003, 8'd0, 3'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, -1, 0, -1, 0, 2'b00, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 64'h8000_0000, 8'd0, 3'd3, 2'b01, 0,                      8'h00, -1, 0, -1, 0, 2'b00, 64'hFF00_0000, 0, 0, 0);
    vecs[7]  = mk(1, 0, 64'h8000_8000, 8'd1, 3'd3, 2'b01, 64'h5A,                 8'hFF, -1, 0, -1, 0, 2'b10, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 64'h8000_8000, 8'd0, 3'd3, 2'b01, 0,                      8'h00, -1, 0, -1, 0, 2'b10, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 64'h8000_0000, 8'd1, 3'd3, 2'b01, 0,                      8'h00, -1, 0, -1, 0, 2'b00, 64'hFF00_0000, 64'h22, 0, 0);
    vecs[10] = mk(1, 0, 64'h8000_0020, 8'd1, 3'd3, 2'b01, 64'h1000,               8'hFF,  0, 5, -1, 0, 2'b10, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 64'h8000_0020, 8'd1, 3'd3, 2'b01, 0,                      8'h00, -1, 0, -1, 0, 2'b00, 64'h1000, 64'h2000, 0, 0);
    vecs[12] = mk(0, 0, 64'h8000_0000, 8'd1, 3'd3, 2'b11, 0,                      8'h00, -1, 0, -1, 0, 2'b10, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 64'h8000_0000, 8'd2, 3'd3, 2'b10, 0,                      8'h00, -1, 0, -1, 0, 2'b10, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 64'h8000_0010, 8'd1, 3'd2, 2'b01, 64'h1111_1111_1111_1111, 8'hFF, -1, 0, -1, 0, 2'b00, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 64'h8000_0010, 8'd0, 3'd3, 2'b01, 0,                      8'h00, -1, 0, -1, 0, 2'b00, 64'h2222_2222_1111_1111, 0, 0, 0);
    vecs[16] = mk(0, 0, 64'h8000_0008, 8'd1, 3'd3, 2'b00, 0,                      8'h00, -1, 0, -1, 0, 2'b00, 64'h22, 64'h22, 0, 0);
    vecs[17] = mk(0, 0, 64'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 0,                      8'h00, -1, 0, -1, 0, 2'b10, 0, 0, 0, 0);

    sel = 1'b0;
    ar_valid = 1'b0; r_ready = 1'b0; aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
    ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
    aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    w_data = '0; w_strb = '0;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("rst.ar_ready", 64'(m_ar_ready), 64'd1);
    check("rst.aw_ready", 64'(m_aw_ready), 64'd1);
    check("rst.r_valid",  64'(m_r_valid),  64'd0);
    check("rst.r_last",   64'(m_r_last),   64'd0);
    check("rst.r_data",   m_r_data,        64'd0);
    check("rst.rresp",    64'(m_rresp),    64'd0);
    check("rst.w_ready",  64'(m_w_ready),  64'd0);
    check("rst.b_valid",  64'(m_b_valid),  64'd0);
    check("rst.bresp",    64'(m_bresp),    64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      sel = vecs[i].sel;
      if (vecs[i].is_wr) do_write(i, vecs[i]);
      else               do_read(i, vecs[i]);
    end

    // Reset in the middle of a four-beat read, after the first beat.
    sel = 1'b0;
    ar_addr = 64'h8000_0000; ar_len = 8'd3; ar_size = 3'd3; ar_burst = 2'b01;
    ar_valid = 1'b1;
    r_ready  = 1'b1;
    tick();
    ar_valid = 1'b0;
    check("mid.beat0_valid", 64'(m_r_valid), 64'd1);
    check("mid.beat0_data",  m_r_data, 64'hFF00_0000);
    tick();
    check("mid.beat1_data",  m_r_data, 64'h22);
    rst_n = 1'b0;
    #1;
    check("mid.rst_r_valid",  64'(m_r_valid),  64'd0);
    check("mid.rst_ar_ready", 64'(m_ar_ready), 64'd1);
    check("mid.rst_r_data",   m_r_data,        64'd0);
    r_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tail = mk(0, 0, 64'h8000_0008, 8'd1, 3'd3, 2'b01, 0, 8'h00, -1, 0, -1, 0, 2'b00,
              64'h22, 64'h2222_2222_1111_1111, 0, 0);
    do_read(100, tail);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
